uart_mem_dumper: RTL
====================

UART_MEM_DUMPER -- requirements
Module: uart_mem_dumper

Interface
REQ-001 Parameter CLK_DIV, default 87; upg_clk_i cycles per UART bit (10 MHz / 115200).
REQ-002 Parameter ADDR_W, default 14; word-address width of the dumped memory.
REQ-003 upg_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 upg_rst_i  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a dump.
REQ-006 base_adr_i  input  ADDR_W  first word address to dump.
REQ-007 word_cnt_i  input  ADDR_W  number of 32-bit words to dump.
REQ-008 mem_adr_o  output  ADDR_W  word address to memory read port.
REQ-009 mem_dat_i  input  32  memory read data; valid exactly one cycle after mem_adr_o changes (synchronous RAM).
REQ-010 busy_o  output  1  high from accepted start until the final stop bit ends.
REQ-011 done_o  output  1  one-cycle pulse when a dump completes.
REQ-012 upg_tx_o  output  1  UART serial output, 8N1, idle high.

Function
REQ-013 FSM states: IDLE, RD_ADDR, RD_DATA, SEND, NEXT, FIN.
REQ-014 IDLE: start_i high -> latch base_adr_i into address register and word_cnt_i into remaining-count register; go to RD_ADDR, or to FIN if word_cnt_i = 0.
REQ-015 start_i while busy_o is high is ignored; inputs latched only at acceptance.
REQ-016 RD_ADDR: mem_adr_o holds current address for one cycle -> RD_DATA.
REQ-017 RD_DATA: capture mem_dat_i into a 32-bit word register -> SEND with byte index 0.
REQ-018 SEND: transmit word bytes LSB first (bits 7:0, 15:8, 23:16, 31:24); after byte 3 stop bit -> NEXT.
REQ-019 NEXT: address +1 modulo 2^ADDR_W (wraps from all-ones to 0); remaining count -1; count reaches 0 -> FIN, else RD_ADDR.
REQ-020 FIN: done_o high for exactly one cycle, busy_o low in the same cycle -> IDLE.
REQ-021 Frame: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLK_DIV cycles; frame = 10*CLK_DIV cycles.
REQ-022 Bytes within a word are back-to-back: the next start bit begins the cycle after the previous stop bit ends.
REQ-023 Between words, upg_tx_o stays high for exactly 3 cycles (NEXT, RD_ADDR, RD_DATA).
REQ-024 upg_tx_o is driven from a flop (glitch-free).
REQ-025 mem_adr_o holds its value outside RD_ADDR; it is never X.

Reset
REQ-026 Reset values: state IDLE, upg_tx_o 1, busy_o 0, done_o 0, mem_adr_o 0, all counters 0.
REQ-027 Reset asserted mid-frame forces upg_tx_o high immediately (asynchronous) and abandons the dump; no done_o pulse.
REQ-028 First start_i is accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Shared package holds the FSM state enum, the UART frame-length constant (10), and the bytes-per-word constant (4).
REQ-030 Sub-module uart_tx (CLK_DIV parameter; ports: byte valid/ready handshake, 8-bit data, tx line) owns bit timing; uart_mem_dumper owns addressing and sequencing.
REQ-031 uart_tx accepts a byte only when ready is high; ready is low from acceptance until the stop bit ends.

Verification (CLK_DIV=4, ADDR_W=14, behavioural synchronous RAM model)
REQ-032 Reset, no start -> upg_tx_o=1, busy_o=0, done_o=0 for 1000 cycles.
REQ-033 mem[5]=32'h12345678, start base=5 cnt=1 -> serial bytes 78,56,34,12, each bit 4 cycles; done_o single pulse; busy_o high for 160 cycles plus overhead.
REQ-034 base=14'h3FFF cnt=2, mem[3FFF]=AABBCCDD, mem[0]=01020304 -> reads 3FFF then 0000; bytes DD,CC,BB,AA,04,03,02,01; 3 idle-high cycles between the two words.
REQ-035 cnt=0 -> done_o pulses 2 cycles after start; upg_tx_o never leaves 1.
REQ-036 start_i repulsed mid-dump with different base -> ignored; output byte stream unchanged.
REQ-037 upg_rst_i asserted during data bit 3 of byte 1 -> upg_tx_o=1 in the same cycle; no done_o; a fresh start afterwards dumps correctly.

Source files
------------

// File: rtl/uart_mem_dumper_pkg.sv
// Shared types and constants for the UART memory dumper.
package uart_mem_dumper_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_DATA,
      S_SEND,
      S_NEXT,
      S_FIN
   } state_e;

   localparam int FRAME_LEN      = 10;
   localparam int BYTES_PER_WORD = 4;

   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      return 8'(word >> {idx, 3'b000});
   endfunction

endpackage

// File: rtl/uart_mem_dumper_if.sv
// Control, memory read port and serial line of the dumper, grouped as one bundle.
interface uart_mem_dumper_if #(
   parameter int ADDR_W = 14
);
   logic              start_i;
   logic [ADDR_W-1:0] base_adr_i;
   logic [ADDR_W-1:0] word_cnt_i;
   logic [ADDR_W-1:0] mem_adr_o;
   logic [31:0]       mem_dat_i;
   logic              busy_o;
   logic              done_o;
   logic              upg_tx_o;

   modport slave (
      input  start_i, base_adr_i, word_cnt_i, mem_dat_i,
      output mem_adr_o, busy_o, done_o, upg_tx_o
   );

   modport master (
      output start_i, base_adr_i, word_cnt_i, mem_dat_i,
      input  mem_adr_o, busy_o, done_o, upg_tx_o
   );
endinterface

// File: rtl/uart_mem_dumper_tx.sv
// 8N1 UART transmitter; ready rises in the last stop-bit cycle so bytes can run back-to-back.
module uart_tx
   import uart_mem_dumper_pkg::*;
#(
   parameter int CLK_DIV = 87
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic       ready_o,
   output logic       tx_o
);
   localparam int CW = $clog2(CLK_DIV + 1);

   logic          active_q;
   logic [CW-1:0] div_q;
   logic [3:0]    bit_q;
   logic [8:0]    shift_q;
   logic          tx_q;
   logic          last_cyc;

   assign last_cyc = active_q && (div_q == '0) && (bit_q == 4'(FRAME_LEN - 1));
   assign ready_o  = !active_q || last_cyc;
   assign tx_o     = tx_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         active_q <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
      end else if (valid_i && ready_o) begin
         active_q <= 1'b1;
         div_q    <= CW'(CLK_DIV - 1);
         bit_q    <= '0;
         shift_q  <= {1'b1, data_i};
         tx_q     <= 1'b0;
      end else if (active_q) begin
         if (div_q != '0) begin
            div_q <= div_q - 1'b1;
         end else if (last_cyc) begin
            active_q <= 1'b0;
            bit_q    <= '0;
         end else begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[8:1]};
            bit_q   <= bit_q + 1'b1;
            div_q   <= CW'(CLK_DIV - 1);
         end
      end
   end
endmodule

// File: rtl/uart_mem_dumper.sv
// Reads a block of 32-bit words from a synchronous RAM and streams them LSB-byte first over UART.
//  state   | meaning
//  IDLE    | waiting for start_i
//  RD_ADDR | address presented to RAM
//  RD_DATA | RAM data captured, byte 0 handed to uart_tx
//  SEND    | remaining bytes of the word, then wait for last stop bit
//  NEXT    | advance address, decrement remaining count
//  FIN     | one-cycle done pulse, busy released
module uart_mem_dumper
   import uart_mem_dumper_pkg::*;
#(
   parameter int CLK_DIV = 87,
   parameter int ADDR_W  = 14
) (
   input  logic              upg_clk_i,
   input  logic              upg_rst_i,
   uart_mem_dumper_if.slave  bus
);
   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [31:0]       word_q;
   logic [1:0]        byte_q;
   logic              tx_valid_q;
   logic              busy_q;
   logic              done_q;
   logic [7:0]        tx_data;
   logic              tx_ready;

   // Byte 0 bypasses word_q so the start bit follows RD_DATA with no extra idle cycle.
   always_comb begin
      tx_data = word_byte(word_q, byte_q);
      if (state_q == S_RD_DATA) tx_data = bus.mem_dat_i[7:0];
   end

   assign bus.mem_adr_o = addr_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;

   always_ff @(posedge upg_clk_i or posedge upg_rst_i) begin
      if (upg_rst_i) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         word_q     <= '0;
         byte_q     <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  addr_q  <= bus.base_adr_i;
                  cnt_q   <= bus.word_cnt_i;
                  busy_q  <= 1'b1;
                  state_q <= (bus.word_cnt_i == '0) ? S_FIN : S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               tx_valid_q <= 1'b1;
               state_q    <= S_RD_DATA;
            end
            S_RD_DATA: begin
               if (tx_ready) begin
                  word_q  <= bus.mem_dat_i;
                  byte_q  <= 2'd1;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_valid_q) begin
                  if (tx_ready) begin
                     if (byte_q == 2'(BYTES_PER_WORD - 1)) tx_valid_q <= 1'b0;
                     else                                  byte_q     <= byte_q + 1'b1;
                  end
               end else if (tx_ready) begin
                  state_q <= S_NEXT;
               end
            end
            S_NEXT: begin
               addr_q  <= addr_q + 1'b1;
               cnt_q   <= cnt_q - 1'b1;
               state_q <= (cnt_q == ADDR_W'(1)) ? S_FIN : S_RD_ADDR;
            end
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk_i   (upg_clk_i),
      .rst_i   (upg_rst_i),
      .valid_i (tx_valid_q),
      .data_i  (tx_data),
      .ready_o (tx_ready),
      .tx_o    (bus.upg_tx_o)
   );
endmodule
